// File: rtl/dkong_dl_pkg.sv
// dkong_dl_pkg: shared constants, region encoding and FSM states for the download router
package dkong_dl_pkg;
  localparam logic [24:0] MAIN_LIM = 25'h0008000;
  localparam logic [24:0] DL_BASE = 25'h0008000;
  localparam logic [24:0] DL_LIM = 25'h000E000;
  localparam logic [24:0] SND_BASE = 25'h000E000;
  localparam logic [24:0] SND_LIM = 25'h000F000;
  localparam logic [24:0] WAV_BASE = 25'h0010000;
  localparam logic [24:0] WAV_LIM = 25'h0020000;
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, READY} state_t;
  typedef struct packed {
    logic dip;
    logic mod;
    logic dl;
    logic wav;
    logic snd;
    logic main;
  } region_t;
endpackage

// File: rtl/dl_region_decode.sv
// dl_region_decode: maps {index, addr} of a download byte to a one-hot target region
import dkong_dl_pkg::*;
module dl_region_decode (
  input  logic [7:0]  index,
  input  logic [24:0] addr,
  output region_t     region,
  output logic [15:0] loc_a
);
  logic rom;
  assign rom = index == IDX_ROM;
  assign region.main = rom && addr < MAIN_LIM;
  assign region.dl = rom && addr >= DL_BASE && addr < DL_LIM;
  assign region.snd = rom && addr >= SND_BASE && addr < SND_LIM;
  assign region.wav = rom && addr >= WAV_BASE && addr < WAV_LIM;
  assign region.dip = index == IDX_DIP && addr[24:3] == 22'd0;
  assign region.mod = index == IDX_MOD;
  assign loc_a = addr[15:0];
endmodule

// File: rtl/dkong_dl_router.sv
// dkong_dl_router: routes ioctl download bytes to ROM/DIP/mod targets and sequences core reset
import dkong_dl_pkg::*;
module dkong_dl_router #(
  parameter int FLUSH_CYCLES = 16,
  parameter int MAIN_BYTES = 32768,
  parameter int SND_BYTES = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        main_we,
  output logic [14:0] main_a,
  output logic        snd_we,
  output logic [11:0] snd_a,
  output logic        wav_we,
  output logic [15:0] wav_a,
  output logic        dl_we,
  output logic [15:0] dl_a,
  output logic [7:0]  wr_data,
  output logic [7:0]  dip_sw0,
  output logic [4:0]  mod_sel,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        busy
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  region_t region, hit;
  logic [15:0] loc_a;
  state_t state, state_n;
  logic [FW-1:0] flush_cnt;
  logic [15:0] main_cnt;
  logic [12:0] snd_cnt;
  logic [7:0][7:0] dip;
  logic [7:0] mod;
  logic rom_dl, ld_entry;

  dl_region_decode u_dec (
    .index(ioctl_index),
    .addr(ioctl_addr),
    .region(region),
    .loc_a(loc_a)
  );

  assign hit = (ioctl_download && ioctl_wr) ? region : '0;
  assign rom_dl = ioctl_download && ioctl_index == IDX_ROM;
  assign ld_entry = state_n == LOAD && state != LOAD;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      core_reset <= 1'b1;
      rom_ok <= 1'b0;
    end else begin
      state <= state_n;
      core_reset <= state_n != READY;
      flush_cnt <= state == LOAD ? FW'(FLUSH_CYCLES - 1) : flush_cnt - FW'(state == FLUSH && flush_cnt != '0);
      if (state == FLUSH && state_n == READY)
        rom_ok <= main_cnt == 16'(MAIN_BYTES) && snd_cnt == 13'(SND_BYTES);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = rom_dl ? LOAD : READY;
      LOAD:    state_n = ioctl_download ? LOAD : FLUSH;
      FLUSH:   state_n = rom_dl ? LOAD : flush_cnt == '0 ? READY : FLUSH;
      default: state_n = rom_dl ? LOAD : READY;
    endcase
  end

  assign busy = state != READY;

  // Counters survive reset so only a fresh LOAD entry clears them.
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      main_cnt <= ld_entry ? 16'(hit.main) : main_cnt + 16'(hit.main && main_cnt != '1);
      snd_cnt <= ld_entry ? 13'(hit.snd) : snd_cnt + 13'(hit.snd && snd_cnt != '1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      main_we <= 1'b0;
      snd_we <= 1'b0;
      wav_we <= 1'b0;
      dl_we <= 1'b0;
      main_a <= '0;
      snd_a <= '0;
      wav_a <= '0;
      dl_a <= '0;
      wr_data <= '0;
      dip <= '0;
      mod <= '0;
    end else begin
      main_we <= hit.main;
      snd_we <= hit.snd;
      wav_we <= hit.wav;
      dl_we <= hit.dl;
      if (hit.main) main_a <= loc_a[14:0];
      if (hit.snd) snd_a <= loc_a[11:0];
      if (hit.wav) wav_a <= loc_a;
      if (hit.dl) dl_a <= loc_a;
      if (hit.main || hit.snd || hit.wav || hit.dl) wr_data <= ioctl_dout;
      if (hit.dip) dip[ioctl_addr[2:0]] <= ioctl_dout;
      if (hit.mod) mod <= ioctl_dout;
    end
  end

  assign dip_sw0 = dip[0];
  assign mod_sel = mod > 8'd4 ? 5'd0 : 5'(5'd1 << mod[2:0]);
endmodule

// File: tb/tb_dkong_dl_router.sv
// tb_dkong_dl_router: directed stimulus with a write-event scoreboard and decoupled monitor
module tb_dkong_dl_router;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic main_we, snd_we, wav_we, dl_we, core_reset, rom_ok, busy;
  logic [14:0] main_a;
  logic [11:0] snd_a;
  logic [15:0] wav_a, dl_a;
  logic [7:0] wr_data, dip_sw0;
  logic [4:0] mod_sel;

  dkong_dl_router dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .main_we(main_we), .main_a(main_a), .snd_we(snd_we), .snd_a(snd_a),
    .wav_we(wav_we), .wav_a(wav_a), .dl_we(dl_we), .dl_a(dl_a), .wr_data(wr_data),
    .dip_sw0(dip_sw0), .mod_sel(mod_sel), .core_reset(core_reset), .rom_ok(rom_ok), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0] port;
    logic [15:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  int tests = 0, fails = 0, main_pulses = 0, nwe;
  logic [14:0] last_main_a = '0;
  bit done = 1'b0;
  ev_t got, e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) if (!done) begin
    nwe = int'(main_we) + int'(snd_we) + int'(wav_we) + int'(dl_we);
    if (nwe > 1) chk("one_we", nwe, 1);
    else if (nwe == 1) begin
      got.port = snd_we ? 2'd1 : wav_we ? 2'd2 : dl_we ? 2'd3 : 2'd0;
      got.a = main_we ? {1'b0, main_a} : snd_we ? {4'b0, snd_a} : wav_we ? wav_a : dl_a;
      got.d = wr_data;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got %h expected none", got);
      end else begin
        e = q.pop_front();
        chk("route", 32'(got), 32'(e));
      end
    end
    if (main_we) begin
      main_pulses++;
      last_main_a = main_a;
    end
  end

  task automatic put(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input int port, input logic [15:0] ea);
    ev_t x;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    if (port >= 0) begin
      x.port = port[1:0];
      x.a = ea;
      x.d = d;
      q.push_back(x);
    end
  endtask

  task automatic open_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_wr = 1'b0;
    ioctl_index = idx;
  endtask

  task automatic stream(input logic [24:0] base, input int n, input int port, input logic [7:0] xr);
    for (int i = 0; i < n; i++) put(8'd0, base + 25'(i), 8'(i) ^ xr, port, 16'(i));
  endtask

  task automatic quiet_close();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
  endtask

  task automatic close_dl(input string name, input logic ok);
    int cnt = 0;
    quiet_close();
    while (core_reset && cnt < 200) begin
      @(negedge clk_sys);
      cnt++;
    end
    chk({name, "_release"}, cnt, 17);
    chk({name, "_rom_ok"}, rom_ok, ok);
    chk({name, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_we", {main_we, snd_we, wav_we, dl_we}, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_mod_sel", mod_sel, 5'b00001);
    chk("rst_dip", dip_sw0, 0);
    chk("rst_rom_ok", rom_ok, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("idle_to_ready", busy, 0);

    main_pulses = 0;
    open_dl(8'd0);
    stream(25'h0000000, 32768, 0, 8'h5A);
    stream(25'h000E000, 4096, 1, 8'hC3);
    close_dl("full", 1'b1);
    chk("full_main_pulses", main_pulses, 32768);
    chk("full_last_main_a", last_main_a, 15'h7FFF);

    open_dl(8'd0);
    put(8'd0, 25'h0008000, 8'h11, 3, 16'h8000);
    put(8'd0, 25'h000DFFF, 8'h22, 3, 16'hDFFF);
    put(8'd0, 25'h000E000, 8'h33, 1, 16'h0000);
    put(8'd0, 25'h000F000, 8'h44, -1, 16'h0000);
    put(8'd0, 25'h0010005, 8'h55, 2, 16'h0005);
    close_dl("bound", 1'b0);

    open_dl(8'd0);
    stream(25'h0000000, 100, 0, 8'h00);
    close_dl("short", 1'b0);

    put(8'd254, 25'h0000000, 8'hA5, -1, 16'h0);
    put(8'd254, 25'h0000008, 8'h3C, -1, 16'h0);
    quiet_close();
    chk("dip_sw0", dip_sw0, 8'hA5);
    chk("dip_busy", busy, 0);

    put(8'd1, 25'h0000000, 8'd4, -1, 16'h0);
    quiet_close();
    chk("mod4", mod_sel, 5'b10000);
    put(8'd1, 25'h0000000, 8'd7, -1, 16'h0);
    quiet_close();
    chk("mod7", mod_sel, 5'b00000);
    chk("mod_busy", busy, 0);
    chk("mod_core_reset", core_reset, 0);

    open_dl(8'd0);
    stream(25'h0000000, 50, 0, 8'h00);
    @(negedge clk_sys);
    reset = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd50;
    @(negedge clk_sys);
    chk("midrst_we", {main_we, snd_we, wav_we, dl_we}, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_busy", busy, 1);
    reset = 1'b0;
    ioctl_wr = 1'b0;
    main_pulses = 0;
    stream(25'h0000000, 32768, 0, 8'h96);
    stream(25'h000E000, 4096, 1, 8'h69);
    close_dl("fresh", 1'b1);
    chk("fresh_main_pulses", main_pulses, 32768);

    repeat (2) @(negedge clk_sys);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
